// File: rtl/arm_mem_arbiter_pkg.sv
// Shared FSM encoding and default timeout for the unified-memory arbiter.
package arm_mem_arb_pkg;

  localparam int unsigned DefTimeoutCycles = 32'd255;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_WAIT = 2'd1,
    DATA_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arm_mem_arbiter_if.sv
// Fetch port, data port, unified memory bus and hazard-unit stall lines.
interface arm_mem_arbiter_if #(
  parameter int unsigned BusWidth = 32'd32
);
  logic                i_Fetch_Req;
  logic [BusWidth-1:0] i_Fetch_Addr;
  logic [BusWidth-1:0] o_Fetch_Data;
  logic                o_Fetch_Valid;
  logic                i_Data_Req;
  logic                i_Data_We;
  logic [BusWidth-1:0] i_Data_Addr;
  logic [BusWidth-1:0] i_Data_WData;
  logic [BusWidth-1:0] o_Data_RData;
  logic                o_Data_Valid;
  logic                o_Stall_Fetch;
  logic                o_Stall_Memory;
  logic                o_Mem_Req;
  logic                o_Mem_We;
  logic [BusWidth-1:0] o_Mem_Addr;
  logic [BusWidth-1:0] o_Mem_WData;
  logic [BusWidth-1:0] i_Mem_RData;
  logic                i_Mem_Ready;
  logic                o_Bus_Error;

  modport slave (
    input  i_Fetch_Req, i_Fetch_Addr, i_Data_Req, i_Data_We, i_Data_Addr,
           i_Data_WData, i_Mem_RData, i_Mem_Ready,
    output o_Fetch_Data, o_Fetch_Valid, o_Data_RData, o_Data_Valid,
           o_Stall_Fetch, o_Stall_Memory, o_Mem_Req, o_Mem_We, o_Mem_Addr,
           o_Mem_WData, o_Bus_Error
  );

  modport master (
    output i_Fetch_Req, i_Fetch_Addr, i_Data_Req, i_Data_We, i_Data_Addr,
           i_Data_WData, i_Mem_RData, i_Mem_Ready,
    input  o_Fetch_Data, o_Fetch_Valid, o_Data_RData, o_Data_Valid,
           o_Stall_Fetch, o_Stall_Memory, o_Mem_Req, o_Mem_We, o_Mem_Addr,
           o_Mem_WData, o_Bus_Error
  );
endinterface

// File: rtl/arm_wait_timer.sv
// Counts WAIT cycles without ready; flags the cycle on which the limit is reached.
module arm_wait_timer
  import arm_mem_arb_pkg::*;
#(
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);
  localparam int unsigned CntW = $clog2(TimeoutCycles + 32'd1);
  localparam logic [CntW-1:0] LimitM1 = CntW'(TimeoutCycles - 32'd1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CntW{1'b0}};
    end else if (tick_i) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {CntW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This tick would make the count reach the limit.
  assign expired_o = tick_i & (cnt_q == LimitM1);

endmodule

// File: rtl/arm_mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one registered memory bus.
module arm_mem_arbiter
  import arm_mem_arb_pkg::*;
#(
  parameter int unsigned BusWidth      = 32'd32,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic             i_CLK,
  input  logic             i_NRESET,
  arm_mem_arbiter_if.slave bus
);
  arb_state_e          state_q, state_d;
  logic                last_data_q, last_data_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [BusWidth-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [BusWidth-1:0] fetch_data_q, fetch_data_d, data_rdata_q, data_rdata_d;
  logic                fetch_valid_q, fetch_valid_d, data_valid_q, data_valid_d;
  logic                bus_err_q, bus_err_d;
  logic                waiting_s, complete_s, expired_s, done_s;
  logic                fetch_pend_s, data_pend_s, grant_ok_s, grant_fetch_s, grant_data_s;

  assign waiting_s  = (state_q != IDLE);
  assign complete_s = waiting_s & bus.i_Mem_Ready;
  assign done_s     = complete_s | expired_s;

  // The port being completed on this edge still holds its request; it is not re-granted.
  assign fetch_pend_s  = bus.i_Fetch_Req & ~((state_q == FETCH_WAIT) & done_s);
  assign data_pend_s   = bus.i_Data_Req & ~((state_q == DATA_WAIT) & done_s);
  assign grant_ok_s    = (state_q == IDLE) | complete_s;
  assign grant_data_s  = grant_ok_s & data_pend_s & ~(fetch_pend_s & last_data_q);
  assign grant_fetch_s = grant_ok_s & fetch_pend_s & ~grant_data_s;

  arm_wait_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_wait_timer (
    .clk_i    (i_CLK),
    .rst_ni   (i_NRESET),
    .clear_i  (grant_fetch_s | grant_data_s | done_s),
    .tick_i   (waiting_s & ~bus.i_Mem_Ready),
    .expired_o(expired_s)
  );

  // Next state, bus registers, result capture and anti-starvation flag.
  always_comb begin
    state_d       = state_q;
    last_data_d   = last_data_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    fetch_data_d  = fetch_data_q;
    data_rdata_d  = data_rdata_q;
    fetch_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    bus_err_d     = bus_err_q | expired_s;

    case (state_q)
      FETCH_WAIT: begin
        if (done_s) begin
          fetch_valid_d = 1'b1;
          fetch_data_d  = expired_s ? {BusWidth{1'b0}} : bus.i_Mem_RData;
        end else begin
          fetch_valid_d = 1'b0;
        end
      end
      DATA_WAIT: begin
        if (done_s) begin
          data_valid_d = 1'b1;
          last_data_d  = 1'b1;
          if (expired_s) begin
            data_rdata_d = {BusWidth{1'b0}};
          end else if (!mem_we_q) begin
            data_rdata_d = bus.i_Mem_RData;
          end else begin
            data_rdata_d = data_rdata_q;
          end
        end else begin
          data_valid_d = 1'b0;
        end
      end
      default: begin
        fetch_valid_d = 1'b0;
        data_valid_d  = 1'b0;
      end
    endcase

    if (grant_data_s) begin
      state_d     = DATA_WAIT;
      mem_req_d   = 1'b1;
      mem_we_d    = bus.i_Data_We;
      mem_addr_d  = bus.i_Data_Addr;
      mem_wdata_d = bus.i_Data_WData;
    end else if (grant_fetch_s) begin
      state_d     = FETCH_WAIT;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = bus.i_Fetch_Addr;
      last_data_d = 1'b0;
    end else if (done_s) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state_q       <= IDLE;
      last_data_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {BusWidth{1'b0}};
      mem_wdata_q   <= {BusWidth{1'b0}};
      fetch_data_q  <= {BusWidth{1'b0}};
      data_rdata_q  <= {BusWidth{1'b0}};
      fetch_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_data_q   <= last_data_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_data_q  <= fetch_data_d;
      data_rdata_q  <= data_rdata_d;
      fetch_valid_q <= fetch_valid_d;
      data_valid_q  <= data_valid_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign bus.o_Mem_Req      = mem_req_q;
  assign bus.o_Mem_We       = mem_we_q;
  assign bus.o_Mem_Addr     = mem_addr_q;
  assign bus.o_Mem_WData    = mem_wdata_q;
  assign bus.o_Fetch_Data   = fetch_data_q;
  assign bus.o_Fetch_Valid  = fetch_valid_q;
  assign bus.o_Data_RData   = data_rdata_q;
  assign bus.o_Data_Valid   = data_valid_q;
  assign bus.o_Bus_Error    = bus_err_q;
  assign bus.o_Stall_Fetch  = bus.i_Fetch_Req & ~((state_q == FETCH_WAIT) & bus.i_Mem_Ready);
  assign bus.o_Stall_Memory = bus.i_Data_Req & ~((state_q == DATA_WAIT) & bus.i_Mem_Ready);

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Directed bench for arm_mem_arbiter with a result scoreboard per port.
module tb_arm_mem_arbiter;
  logic clk;
  logic nreset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] fetch_q[$];
  logic [31:0] data_q[$];

  arm_mem_arbiter_if #(.BusWidth(32)) bus_if ();

  arm_mem_arbiter #(.BusWidth(32), .TimeoutCycles(255)) dut (
    .i_CLK   (clk),
    .i_NRESET(nreset),
    .bus     (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_fetch(input string tag);
    logic [31:0] e;
    check({tag, "_valid"}, {31'd0, bus_if.o_Fetch_Valid}, 32'd1);
    if (fetch_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed empty fetch scoreboard expected an entry", tag);
    end else begin
      e = fetch_q.pop_front();
      check({tag, "_data"}, bus_if.o_Fetch_Data, e);
    end
  endtask

  task automatic check_data(input string tag);
    logic [31:0] e;
    check({tag, "_valid"}, {31'd0, bus_if.o_Data_Valid}, 32'd1);
    if (data_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed empty data scoreboard expected an entry", tag);
    end else begin
      e = data_q.pop_front();
      check({tag, "_data"}, bus_if.o_Data_RData, e);
    end
  endtask

  initial begin
    int cnt;
    nreset               = 1'b0;
    bus_if.i_Fetch_Req   = 1'b0;
    bus_if.i_Fetch_Addr  = 32'h0;
    bus_if.i_Data_Req    = 1'b0;
    bus_if.i_Data_We     = 1'b0;
    bus_if.i_Data_Addr   = 32'h0;
    bus_if.i_Data_WData  = 32'h0;
    bus_if.i_Mem_RData   = 32'h0;
    bus_if.i_Mem_Ready   = 1'b0;
    #12;
    check("rst_mem_req", {31'd0, bus_if.o_Mem_Req}, 32'd0);
    check("rst_mem_addr", bus_if.o_Mem_Addr, 32'h0);
    check("rst_fvalid", {31'd0, bus_if.o_Fetch_Valid}, 32'd0);
    check("rst_dvalid", {31'd0, bus_if.o_Data_Valid}, 32'd0);
    check("rst_buserr", {31'd0, bus_if.o_Bus_Error}, 32'd0);
    nreset = 1'b1;
    step();

    // Fetch only, ready on the third WAIT cycle
    bus_if.i_Fetch_Req  = 1'b1;
    bus_if.i_Fetch_Addr = 32'h0000_0010;
    fetch_q.push_back(32'hE3A0_0001);
    #1 check("t1_stall_idle", {31'd0, bus_if.o_Stall_Fetch}, 32'd1);
    step();
    check("t1_mem_req", {31'd0, bus_if.o_Mem_Req}, 32'd1);
    check("t1_mem_addr", bus_if.o_Mem_Addr, 32'h0000_0010);
    check("t1_mem_we", {31'd0, bus_if.o_Mem_We}, 32'd0);
    step();
    check("t1_stall_wait", {31'd0, bus_if.o_Stall_Fetch}, 32'd1);
    step();
    bus_if.i_Mem_Ready = 1'b1;
    bus_if.i_Mem_RData = 32'hE3A0_0001;
    #1 check("t1_stall_ready", {31'd0, bus_if.o_Stall_Fetch}, 32'd0);
    step();
    check_fetch("t1_fetch");
    check("t1_req_drop", {31'd0, bus_if.o_Mem_Req}, 32'd0);
    bus_if.i_Mem_Ready = 1'b0;
    bus_if.i_Fetch_Req = 1'b0;
    step();
    check("t1_one_pulse", {31'd0, bus_if.o_Fetch_Valid}, 32'd0);

    // Simultaneous fetch and load: load first, fetch granted on completion
    bus_if.i_Fetch_Req  = 1'b1;
    bus_if.i_Fetch_Addr = 32'h0000_0020;
    bus_if.i_Data_Req   = 1'b1;
    bus_if.i_Data_We    = 1'b0;
    bus_if.i_Data_Addr  = 32'h0000_0100;
    data_q.push_back(32'h1111_1111);
    fetch_q.push_back(32'h2222_2222);
    step();
    check("t2_first_addr", bus_if.o_Mem_Addr, 32'h0000_0100);
    bus_if.i_Mem_Ready = 1'b1;
    bus_if.i_Mem_RData = 32'h1111_1111;
    #1;
    check("t2_stall_mem", {31'd0, bus_if.o_Stall_Memory}, 32'd0);
    check("t2_stall_fetch", {31'd0, bus_if.o_Stall_Fetch}, 32'd1);
    step();
    check_data("t2_load");
    check("t2_no_idle_req", {31'd0, bus_if.o_Mem_Req}, 32'd1);
    check("t2_second_addr", bus_if.o_Mem_Addr, 32'h0000_0020);
    bus_if.i_Data_Req  = 1'b0;
    bus_if.i_Mem_Ready = 1'b0;
    step();
    check("t2_dvalid_low", {31'd0, bus_if.o_Data_Valid}, 32'd0);
    bus_if.i_Mem_Ready = 1'b1;
    bus_if.i_Mem_RData = 32'h2222_2222;
    step();
    check_fetch("t2_fetch");
    bus_if.i_Fetch_Req = 1'b0;
    bus_if.i_Mem_Ready = 1'b0;
    step();

    // Store: RData untouched
    bus_if.i_Data_Req   = 1'b1;
    bus_if.i_Data_We    = 1'b1;
    bus_if.i_Data_Addr  = 32'h0000_0200;
    bus_if.i_Data_WData = 32'hDEAD_BEEF;
    data_q.push_back(32'h1111_1111);
    step();
    check("t3_we", {31'd0, bus_if.o_Mem_We}, 32'd1);
    check("t3_wdata", bus_if.o_Mem_WData, 32'hDEAD_BEEF);
    check("t3_addr", bus_if.o_Mem_Addr, 32'h0000_0200);
    step();
    bus_if.i_Mem_Ready = 1'b1;
    bus_if.i_Mem_RData = 32'hBAD0_BAD0;
    step();
    check_data("t3_store");
    bus_if.i_Data_Req  = 1'b0;
    bus_if.i_Data_We   = 1'b0;
    bus_if.i_Mem_Ready = 1'b0;
    step();

    // Continuous requests on both ports alternate; ready held high, also in IDLE
    bus_if.i_Fetch_Req  = 1'b1;
    bus_if.i_Fetch_Addr = 32'h0000_0040;
    bus_if.i_Data_Req   = 1'b1;
    bus_if.i_Data_Addr  = 32'h0000_0300;
    bus_if.i_Mem_Ready  = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4_addr%0d", i), bus_if.o_Mem_Addr,
            (i % 2 == 0) ? 32'h0000_0040 : 32'h0000_0300);
      if (i > 0) begin
        if (i % 2 == 1) check_fetch($sformatf("t4_tx%0d", i - 1));
        else            check_data($sformatf("t4_tx%0d", i - 1));
      end
      bus_if.i_Mem_RData = 32'hA000_0000 + 32'(i);
      if (i % 2 == 0) fetch_q.push_back(32'hA000_0000 + 32'(i));
      else            data_q.push_back(32'hA000_0000 + 32'(i));
      if (i == 5) begin
        bus_if.i_Fetch_Req = 1'b0;
        bus_if.i_Data_Req  = 1'b0;
      end
      step();
    end
    check_data("t4_tx5");
    check("t4_idle_req", {31'd0, bus_if.o_Mem_Req}, 32'd0);
    bus_if.i_Mem_Ready = 1'b0;
    step();

    // Timeout abort after 255 WAIT cycles
    bus_if.i_Data_Req  = 1'b1;
    bus_if.i_Data_Addr = 32'h0000_0400;
    data_q.push_back(32'h0);
    step();
    cnt = 0;
    while (bus_if.o_Data_Valid !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
    check("t5_latency", 32'(cnt), 32'd255);
    check_data("t5_abort");
    check("t5_buserr", {31'd0, bus_if.o_Bus_Error}, 32'd1);
    check("t5_req_drop", {31'd0, bus_if.o_Mem_Req}, 32'd0);
    bus_if.i_Data_Req   = 1'b0;
    bus_if.i_Fetch_Req  = 1'b1;
    bus_if.i_Fetch_Addr = 32'h0000_0050;
    fetch_q.push_back(32'h5555_AAAA);
    step();
    bus_if.i_Mem_Ready = 1'b1;
    bus_if.i_Mem_RData = 32'h5555_AAAA;
    step();
    check_fetch("t5_after");
    check("t5_sticky", {31'd0, bus_if.o_Bus_Error}, 32'd1);
    bus_if.i_Fetch_Req = 1'b0;
    bus_if.i_Mem_Ready = 1'b0;
    step();

    // Asynchronous reset in DATA_WAIT
    bus_if.i_Data_Req  = 1'b1;
    bus_if.i_Data_Addr = 32'h0000_0500;
    step();
    check("t6_pre_req", {31'd0, bus_if.o_Mem_Req}, 32'd1);
    #2 nreset = 1'b0;
    #1;
    check("t6_async_req", {31'd0, bus_if.o_Mem_Req}, 32'd0);
    check("t6_async_addr", bus_if.o_Mem_Addr, 32'h0);
    check("t6_async_err", {31'd0, bus_if.o_Bus_Error}, 32'd0);
    check("t6_async_fdata", bus_if.o_Fetch_Data, 32'h0);
    check("t6_async_ddata", bus_if.o_Data_RData, 32'h0);
    bus_if.i_Data_Req = 1'b0;
    #1 nreset = 1'b1;
    step();
    check("t6_idle", {31'd0, bus_if.o_Mem_Req}, 32'd0);
    bus_if.i_Fetch_Req  = 1'b1;
    bus_if.i_Fetch_Addr = 32'h0000_0060;
    fetch_q.push_back(32'h6666_0000);
    step();
    check("t6_grant_req", {31'd0, bus_if.o_Mem_Req}, 32'd1);
    check("t6_grant_addr", bus_if.o_Mem_Addr, 32'h0000_0060);
    bus_if.i_Mem_Ready = 1'b1;
    bus_if.i_Mem_RData = 32'h6666_0000;
    step();
    check_fetch("t6_fetch");
    bus_if.i_Fetch_Req = 1'b0;
    bus_if.i_Mem_Ready = 1'b0;
    step();

    check("sb_empty", 32'(fetch_q.size() + data_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
